// File: rtl/result_writer_pkg.sv
// -----------------------------------------------------------------------------
// result_writer_pkg
//   Shared definitions for the result write-back path:
//     type_t      - result format select driven by the core
//     wb_state_t  - write-back FSM states
//     NBEATS32 / NBEATS16 - beats per tile for the default 8x8 array
//     is_fp16()   - format decode used wherever 16-bit packing is selected
// -----------------------------------------------------------------------------
package result_writer_pkg;

    typedef enum logic [1:0] {
        TYPE_INT8  = 2'd0,
        TYPE_INT32 = 2'd1,
        TYPE_FP16  = 2'd2,
        TYPE_FP32  = 2'd3
    } type_t;

    typedef enum logic [1:0] {
        WB_IDLE       = 2'd0,
        WB_WAIT_READY = 2'd1,
        WB_SEND       = 2'd2,
        WB_DONE       = 2'd3
    } wb_state_t;

    // Beats per tile for the default L=8 array: one row per beat in 32-bit
    // mode, two rows per beat in FP16 mode.
    localparam int NBEATS32 = 8;
    localparam int NBEATS16 = 4;

    function automatic logic is_fp16(input type_t fmt);
        return fmt == TYPE_FP16;
    endfunction

endpackage

// File: rtl/result_writer_pack.sv
// -----------------------------------------------------------------------------
// result_writer_pack
//   Combinational lane mapper: selects and packs one write beat out of a
//   result tile.
//     32-bit mode: beat b = row b, column c at bits [c*WIDTH +: WIDTH].
//     FP16 mode  : beat b = row 2b in the lower half, row 2b+1 in the upper
//                  half, column c at a 16-bit offset c*16 within its half,
//                  lane value = low 16 bits of the accumulator.
//   Ports:
//     tile_i  - result tile, indexed [row][col]
//     beat_i  - beat index within the tile
//     fmt_i   - result format (FP16 selects 16-bit packing)
//     beat_o  - packed BUS-bit beat
// -----------------------------------------------------------------------------
module result_writer_pack
    import result_writer_pkg::*;
#(
    parameter int L     = 8,
    parameter int WIDTH = 32,
    parameter int BUS   = 256,
    parameter int IDX_W = 3
) (
    input  logic [L-1:0][L-1:0][WIDTH-1:0] tile_i,
    input  logic [IDX_W-1:0]               beat_i,
    input  type_t                          fmt_i,
    output logic [BUS-1:0]                 beat_o
);

    localparam int HALF = BUS / 2;

    // Row selection is written as a compare against every row so the mux
    // never indexes past the array, whatever the beat index holds.
    always_comb begin
        // NOTE: default every output first so no path through the block
        // leaves it unassigned and infers a latch.
        beat_o = '0;
        for (int r = 0; r < L; r++) begin
            if (!is_fp16(fmt_i)) begin
                if (beat_i == IDX_W'(r)) begin
                    for (int c = 0; c < L; c++) begin
                        beat_o[c*WIDTH +: WIDTH] = tile_i[r][c];
                    end
                end
            end else begin
                if (beat_i == IDX_W'(r / 2)) begin
                    for (int c = 0; c < L; c++) begin
                        beat_o[(r % 2)*HALF + c*16 +: 16] = tile_i[r][c][15:0];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/result_writer.sv
// -----------------------------------------------------------------------------
// result_writer
//   Writes one systolic result tile to a valid/ready sink as a burst of
//   BUS-bit beats. On start it waits for every PE to flag its result, takes a
//   single snapshot of the accumulators, then streams the beats with
//   registered payload, burst index and last flag, and pulses done.
//   Ports:
//     clk, rst     - clock, synchronous active-high reset
//     start        - write-back request (honoured only in IDLE)
//     data_type    - result format, FP16 selects 16-bit packing
//     out_sum      - accumulator array [row][col]
//     out_ready    - per-PE result-valid mask
//     wr_valid/wr_ready - beat handshake
//     wr_data      - beat payload
//     wr_burst_id  - beat index within the tile
//     wr_last      - final beat of the tile
//     busy         - FSM not in IDLE
//     done         - one-cycle tile completion pulse
//   BUS must equal L*WIDTH.
// -----------------------------------------------------------------------------
module result_writer
    import result_writer_pkg::*;
#(
    parameter int L     = 8,
    parameter int WIDTH = 32,
    parameter int BUS   = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  type_t                          data_type,
    input  logic [L-1:0][L-1:0][WIDTH-1:0] out_sum,
    input  logic [L-1:0][L-1:0]            out_ready,
    output logic                           wr_valid,
    input  logic                           wr_ready,
    output logic [BUS-1:0]                 wr_data,
    output logic [31:0]                    wr_burst_id,
    output logic                           wr_last,
    output logic                           busy,
    output logic                           done
);

    localparam int IDX_W = (L > 1) ? $clog2(L) : 1;

    wb_state_t                      state_q, state_d;
    logic [31:0]                    beat_q, beat_d;
    logic [BUS-1:0]                 data_q, data_d;
    logic                           last_q, last_d;
    logic                           snap;

    logic [L-1:0][L-1:0][WIDTH-1:0] tile_q;
    type_t                          fmt_q;

    logic [L-1:0][L-1:0][WIDTH-1:0] pack_tile;
    type_t                          pack_fmt;
    logic [IDX_W-1:0]               pack_idx;
    logic [BUS-1:0]                 pack_beat;

    // Index of the final beat for a given format.
    function automatic logic [31:0] last_idx(input type_t fmt);
        return is_fp16(fmt) ? 32'(L/2 - 1) : 32'(L - 1);
    endfunction

    result_writer_pack #(
        .L     (L),
        .WIDTH (WIDTH),
        .BUS   (BUS),
        .IDX_W (IDX_W)
    ) u_pack (
        .tile_i (pack_tile),
        .beat_i (pack_idx),
        .fmt_i  (pack_fmt),
        .beat_o (pack_beat)
    );

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        data_d    = data_q;
        last_d    = last_q;
        snap      = 1'b0;
        // By default the packer prepares the beat after the one on the bus so
        // it can be registered on the handshake cycle without a bubble.
        pack_tile = tile_q;
        pack_fmt  = fmt_q;
        pack_idx  = beat_q[IDX_W-1:0] + IDX_W'(1);

        case (state_q)
            WB_IDLE: begin
                if (start) begin
                    state_d = WB_WAIT_READY;
                end
            end
            WB_WAIT_READY: begin
                // Beat 0 is packed straight from the live array in the
                // snapshot cycle, since the tile buffer only loads at the
                // end of this cycle.
                pack_tile = out_sum;
                pack_fmt  = data_type;
                pack_idx  = '0;
                if (&out_ready) begin
                    snap    = 1'b1;
                    beat_d  = '0;
                    data_d  = pack_beat;
                    last_d  = (last_idx(data_type) == 32'd0);
                    state_d = WB_SEND;
                end
            end
            WB_SEND: begin
                if (wr_ready) begin
                    if (last_q) begin
                        state_d = WB_DONE;
                    end else begin
                        beat_d = beat_q + 32'd1;
                        data_d = pack_beat;
                        last_d = ((beat_q + 32'd1) == last_idx(fmt_q));
                    end
                end
            end
            WB_DONE: begin
                state_d = WB_IDLE;
            end
            default: begin
                state_d = WB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q <= WB_IDLE;
            beat_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    // NOTE: the tile buffer is deliberately not reset; it is always written
    // by a snapshot before any beat reads it, and a reset here would only
    // add a wide reset fan-out for no functional gain.
    always_ff @(posedge clk) begin
        if (snap) begin
            tile_q <= out_sum;
            fmt_q  <= data_type;
        end
    end

    assign wr_valid    = (state_q == WB_SEND);
    assign wr_data     = data_q;
    assign wr_burst_id = beat_q;
    assign wr_last     = last_q;
    assign busy        = (state_q != WB_IDLE);
    assign done        = (state_q == WB_DONE);

endmodule

// File: tb/tb_result_writer.sv
// -----------------------------------------------------------------------------
// tb_result_writer
//   Directed bench for result_writer (L=8, WIDTH=32, BUS=256). Each scenario
//   task drives one tile and compares the collected beats against values the
//   bench derives from the tile it presented, plus hand-computed lane values.
//   Cycle numbering inside a tile: cycle 0 is the cycle start is presented.
// -----------------------------------------------------------------------------
module tb_result_writer;
    import result_writer_pkg::*;

    localparam int L     = 8;
    localparam int WIDTH = 32;
    localparam int BUS   = 256;

    logic                           clk = 1'b0;
    logic                           rst;
    logic                           start;
    type_t                          data_type;
    logic [L-1:0][L-1:0][WIDTH-1:0] out_sum;
    logic [L-1:0][L-1:0]            out_ready;
    logic                           wr_valid;
    logic                           wr_ready;
    logic [BUS-1:0]                 wr_data;
    logic [31:0]                    wr_burst_id;
    logic                           wr_last;
    logic                           busy;
    logic                           done;

    always #5 clk = ~clk;

    result_writer #(
        .L     (L),
        .WIDTH (WIDTH),
        .BUS   (BUS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .data_type   (data_type),
        .out_sum     (out_sum),
        .out_ready   (out_ready),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .wr_burst_id (wr_burst_id),
        .wr_last     (wr_last),
        .busy        (busy),
        .done        (done)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [BUS-1:0] got_data[$];
    logic [31:0]    got_id[$];
    logic           got_last[$];
    int             got_cyc[$];
    int             done_cnt;
    int             done_cyc;
    int             first_valid;
    bit             stall_changed;
    bit             valid_drop;
    bit             valid_after_done;

    logic [L-1:0][L-1:0][WIDTH-1:0] snap_tile;

    // Expected beat from a known tile.
    function automatic logic [BUS-1:0] exp_beat(input logic [L-1:0][L-1:0][WIDTH-1:0] t,
                                                input int b, input bit fp16);
        logic [BUS-1:0] v;
        v = '0;
        for (int c = 0; c < L; c++) begin
            if (!fp16) begin
                v[c*32 +: 32] = t[b][c];
            end else begin
                v[c*16 +: 16]       = t[2*b][c][15:0];
                v[128 + c*16 +: 16] = t[2*b+1][c][15:0];
            end
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_pattern32();
        for (int r = 0; r < L; r++)
            for (int c = 0; c < L; c++)
                out_sum[r][c] = 32'(r*16 + c);
    endtask

    task automatic set_pattern16();
        for (int r = 0; r < L; r++)
            for (int c = 0; c < L; c++)
                out_sum[r][c] = 32'hABCD_0000 | 32'((r << 4) | c);
    endtask

    // Drives one tile and records every transferred beat. Options:
    //   ready_delay  - out_ready row 0 incomplete for this many cycles after start;
    //                  the tile in snap_tile appears on out_sum in the completing cycle
    //   stall_pat    - wr_ready follows 1,0,0,1 over the valid cycles
    //   perturb      - out_sum flips every valid cycle
    //   extra_starts - start pulsed mid-burst and in the done cycle
    //   stop_after   - return once this many beats have been accepted
    task automatic run_tile(input int ready_delay, input bit stall_pat, input bit perturb,
                            input bit extra_starts, input int stop_after, input int max_cyc);
        int             vc;
        bit             prev_stall;
        logic [BUS-1:0] prev_data;
        logic [31:0]    prev_id;
        vc = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        prev_id = '0;
        got_data.delete();
        got_id.delete();
        got_last.delete();
        got_cyc.delete();
        done_cnt = 0;
        done_cyc = -1;
        first_valid = -1;
        stall_changed = 1'b0;
        valid_drop = 1'b0;
        valid_after_done = 1'b0;
        wr_ready = 1'b1;
        cyc = 0;
        start = 1'b1;
        while (cyc < max_cyc) begin
            step();
            start = 1'b0;
            if (ready_delay > 0 && cyc == ready_delay + 1) begin
                out_ready = '1;
                out_sum = snap_tile;
            end
            if (ready_delay > 0 && cyc == ready_delay + 2) out_sum = ~snap_tile;
            if (prev_stall && (wr_data !== prev_data || wr_burst_id !== prev_id)) stall_changed = 1'b1;
            if (prev_stall && wr_valid !== 1'b1) valid_drop = 1'b1;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                if (extra_starts) start = 1'b1;
            end
            if (done_cyc >= 0 && cyc > done_cyc && wr_valid === 1'b1) valid_after_done = 1'b1;
            wr_ready = 1'b1;
            if (wr_valid === 1'b1) begin
                if (first_valid < 0) first_valid = cyc;
                wr_ready = (!stall_pat || (vc % 4) == 0 || (vc % 4) == 3);
                vc++;
                if (perturb) out_sum = ~out_sum;
                if (extra_starts && got_id.size() == 3) start = 1'b1;
                if (wr_ready) begin
                    got_data.push_back(wr_data);
                    got_id.push_back(wr_burst_id);
                    got_last.push_back(wr_last);
                    got_cyc.push_back(cyc);
                end
            end
            prev_stall = (wr_valid === 1'b1) && !wr_ready;
            prev_data = wr_data;
            prev_id = wr_burst_id;
            if (stop_after > 0 && got_id.size() == stop_after) break;
            if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        wr_ready = 1'b1;
        data_type = TYPE_FP32;
        out_ready = '1;
        set_pattern32();
        step();
        step();
        n_cmp++; if (wr_valid !== 1'b0) begin n_err++; $display("FAIL reset_wr_valid: got %b expected 0", wr_valid); end
        n_cmp++; if (wr_last !== 1'b0) begin n_err++; $display("FAIL reset_wr_last: got %b expected 0", wr_last); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (wr_data !== '0) begin n_err++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
        n_cmp++; if (wr_burst_id !== 32'd0) begin n_err++; $display("FAIL reset_burst_id: got %0d expected 0", wr_burst_id); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_fp32_tile();
        logic [31:0] lane;
        set_pattern32();
        snap_tile = out_sum;
        data_type = TYPE_FP32;
        out_ready = '1;
        run_tile(0, 1'b0, 1'b0, 1'b0, 0, 40);
        n_cmp++; if (got_id.size() != 8) begin n_err++; $display("FAIL fp32_beats: got %0d expected 8", got_id.size()); end
        for (int b = 0; b < got_id.size(); b++) begin
            n_cmp++; if (got_id[b] !== 32'(b)) begin n_err++; $display("FAIL fp32_id[%0d]: got %0d expected %0d", b, got_id[b], b); end
            n_cmp++; if (got_last[b] !== (b == 7)) begin n_err++; $display("FAIL fp32_last[%0d]: got %b expected %b", b, got_last[b], (b == 7)); end
            n_cmp++; if (got_data[b] !== exp_beat(snap_tile, b, 1'b0)) begin n_err++; $display("FAIL fp32_data[%0d]: got %h expected %h", b, got_data[b], exp_beat(snap_tile, b, 1'b0)); end
            n_cmp++; if (got_cyc[b] != 2 + b) begin n_err++; $display("FAIL fp32_xfer_cycle[%0d]: got %0d expected %0d", b, got_cyc[b], 2 + b); end
        end
        lane = (got_data.size() > 3) ? got_data[3][5*32 +: 32] : 32'hFFFF_FFFF;
        n_cmp++; if (lane !== 32'h35) begin n_err++; $display("FAIL fp32_beat3_lane5: got %h expected 35", lane); end
        n_cmp++; if (first_valid != 2) begin n_err++; $display("FAIL fp32_first_beat_cycle: got %0d expected 2", first_valid); end
        // start presented in cycle 0, done in cycle 10: the 11th cycle of the transaction.
        n_cmp++; if (done_cyc != 10) begin n_err++; $display("FAIL fp32_done_cycle: got %0d expected 10", done_cyc); end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL fp32_done_count: got %0d expected 1", done_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL fp32_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_fp16_tile();
        logic [15:0] lo;
        logic [15:0] hi;
        set_pattern16();
        snap_tile = out_sum;
        data_type = TYPE_FP16;
        out_ready = '1;
        run_tile(0, 1'b0, 1'b0, 1'b0, 0, 40);
        n_cmp++; if (got_id.size() != 4) begin n_err++; $display("FAIL fp16_beats: got %0d expected 4", got_id.size()); end
        for (int b = 0; b < got_id.size(); b++) begin
            n_cmp++; if (got_id[b] !== 32'(b)) begin n_err++; $display("FAIL fp16_id[%0d]: got %0d expected %0d", b, got_id[b], b); end
            n_cmp++; if (got_last[b] !== (b == 3)) begin n_err++; $display("FAIL fp16_last[%0d]: got %b expected %b", b, got_last[b], (b == 3)); end
            n_cmp++; if (got_data[b] !== exp_beat(snap_tile, b, 1'b1)) begin n_err++; $display("FAIL fp16_data[%0d]: got %h expected %h", b, got_data[b], exp_beat(snap_tile, b, 1'b1)); end
        end
        lo = (got_data.size() > 1) ? got_data[1][15:0] : 16'hFFFF;
        hi = (got_data.size() > 1) ? got_data[1][143:128] : 16'hFFFF;
        n_cmp++; if (lo !== 16'h0020) begin n_err++; $display("FAIL fp16_beat1_lo: got %h expected 0020", lo); end
        n_cmp++; if (hi !== 16'h0030) begin n_err++; $display("FAIL fp16_beat1_hi: got %h expected 0030", hi); end
        n_cmp++; if (done_cyc != 6) begin n_err++; $display("FAIL fp16_done_cycle: got %0d expected 6", done_cyc); end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL fp16_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_wait_ready();
        set_pattern32();
        for (int r = 0; r < L; r++)
            for (int c = 0; c < L; c++)
                snap_tile[r][c] = out_sum[r][c] ^ 32'h0000_1000;
        out_sum = {(L*L){32'hDEAD_BEEF}};
        data_type = TYPE_INT32;
        out_ready = '1;
        out_ready[0] = 8'hFE;
        run_tile(5, 1'b0, 1'b0, 1'b0, 0, 50);
        n_cmp++; if (first_valid != 7) begin n_err++; $display("FAIL wait_first_beat_cycle: got %0d expected 7", first_valid); end
        n_cmp++; if (got_id.size() != 8) begin n_err++; $display("FAIL wait_beats: got %0d expected 8", got_id.size()); end
        for (int b = 0; b < got_id.size(); b++) begin
            n_cmp++; if (got_data[b] !== exp_beat(snap_tile, b, 1'b0)) begin n_err++; $display("FAIL wait_data[%0d]: got %h expected %h", b, got_data[b], exp_beat(snap_tile, b, 1'b0)); end
        end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL wait_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_stall();
        set_pattern32();
        snap_tile = out_sum;
        data_type = TYPE_FP32;
        out_ready = '1;
        run_tile(0, 1'b1, 1'b1, 1'b0, 0, 80);
        n_cmp++; if (stall_changed) begin n_err++; $display("FAIL stall_hold: got changed expected stable"); end
        n_cmp++; if (valid_drop) begin n_err++; $display("FAIL stall_valid_drop: got dropped expected held"); end
        n_cmp++; if (got_id.size() != 8) begin n_err++; $display("FAIL stall_beats: got %0d expected 8", got_id.size()); end
        for (int b = 0; b < got_id.size(); b++) begin
            n_cmp++; if (got_id[b] !== 32'(b)) begin n_err++; $display("FAIL stall_id[%0d]: got %0d expected %0d", b, got_id[b], b); end
            n_cmp++; if (got_data[b] !== exp_beat(snap_tile, b, 1'b0)) begin n_err++; $display("FAIL stall_data[%0d]: got %h expected %h", b, got_data[b], exp_beat(snap_tile, b, 1'b0)); end
        end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL stall_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_reset_abort();
        bit stray;
        set_pattern32();
        snap_tile = out_sum;
        data_type = TYPE_FP32;
        out_ready = '1;
        run_tile(0, 1'b0, 1'b0, 1'b0, 2, 40);
        step();
        rst = 1'b1;
        step();
        n_cmp++; if (wr_valid !== 1'b0) begin n_err++; $display("FAIL abort_wr_valid: got %b expected 0", wr_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b expected 0", done); end
        n_cmp++; if (wr_burst_id !== 32'd0) begin n_err++; $display("FAIL abort_burst_id: got %0d expected 0", wr_burst_id); end
        rst = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done !== 1'b0 || wr_valid !== 1'b0) stray = 1'b1;
        end
        n_cmp++; if (stray) begin n_err++; $display("FAIL abort_quiet: got activity expected none"); end
        run_tile(0, 1'b0, 1'b0, 1'b0, 0, 40);
        n_cmp++; if (got_id.size() != 8) begin n_err++; $display("FAIL abort_retile_beats: got %0d expected 8", got_id.size()); end
        for (int b = 0; b < got_id.size(); b++) begin
            n_cmp++; if (got_id[b] !== 32'(b)) begin n_err++; $display("FAIL abort_retile_id[%0d]: got %0d expected %0d", b, got_id[b], b); end
        end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL abort_retile_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_start_ignored();
        set_pattern32();
        snap_tile = out_sum;
        data_type = TYPE_FP32;
        out_ready = '1;
        run_tile(0, 1'b0, 1'b0, 1'b1, 0, 40);
        n_cmp++; if (got_id.size() != 8) begin n_err++; $display("FAIL ignore_beats: got %0d expected 8", got_id.size()); end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL ignore_done_count: got %0d expected 1", done_cnt); end
        n_cmp++; if (valid_after_done) begin n_err++; $display("FAIL ignore_second_tile: got beats after done expected none"); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_busy_after: got %b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_fp32_tile();
        test_fp16_tile();
        test_wait_ready();
        test_stall();
        test_reset_abort();
        test_start_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
